// File: rtl/display_pkg.sv
// Shared constants and helpers for the display scan controller.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;
  localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  // Active-low one-hot anode pattern for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] sel_to_anode(input logic [SEL_W-1:0] sel);
    logic [NUM_DIGITS-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return ~onehot;
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Value-load and display signals between a host and the scan controller.
import display_pkg::*;

interface display_scan_controller_if;
  logic                  enable;
  logic [VALUE_W-1:0]    loadValue;
  logic                  loadStrobe;
  logic [NUM_DIGITS-1:0] blankMask;
  logic [VALUE_W-1:0]    displayInfo;
  logic [SEL_W-1:0]      selection;
  logic [NUM_DIGITS-1:0] anode;
  logic                  pending;
  logic                  loadAck;

  modport master (
    output enable, loadValue, loadStrobe, blankMask,
    input  displayInfo, selection, anode, pending, loadAck
  );

  modport slave (
    input  enable, loadValue, loadStrobe, blankMask,
    output displayInfo, selection, anode, pending, loadAck
  );
endinterface

// File: rtl/display_scan_controller_tick_divider.sv
// Free-running 0..TICKS-1 counter with a terminal-count tick; holds while en is low.
import display_pkg::*;

module tick_divider #(
  parameter int TICKS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  output logic [$clog2(TICKS)-1:0] count,
  output logic                     tick
);

  localparam int CW = $clog2(TICKS);

  logic [CW-1:0] count_q, count_d;

  assign tick  = en && (count_q == CW'(TICKS - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Digit scanner for a 4-digit seven-segment decoder with frame-aligned value commit.
import display_pkg::*;

module display_scan_controller #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  display_scan_controller_if.slave bus
);

  localparam int COUNT_W = $clog2(TICKS_PER_DIGIT);

  logic [COUNT_W-1:0]  prescaler;
  logic                tick;
  logic                in_blank;
  logic                commit_evt;
  logic                do_commit;

  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [VALUE_W-1:0]  disp_q, disp_d;
  logic [VALUE_W-1:0]  shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                ack_q, ack_d;

  tick_divider #(.TICKS(TICKS_PER_DIGIT)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (bus.enable),
    .count (prescaler),
    .tick  (tick)
  );

  generate
    if (BLANK_TICKS > 0) begin : g_blank
      assign in_blank = (prescaler < COUNT_W'(BLANK_TICKS));
    end else begin : g_no_blank
      assign in_blank = 1'b0;
    end
  endgenerate

  // Frame boundary: leaving digit 3, or any edge while the display is off.
  assign commit_evt = (tick && (sel_q == SEL_W'(NUM_DIGITS - 1))) || !bus.enable;
  assign do_commit  = commit_evt && (pending_q || bus.loadStrobe);

  always_comb begin
    sel_d     = sel_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ack_d     = 1'b0;

    if (tick) begin
      sel_d = sel_q + SEL_W'(1);
    end

    if (do_commit) begin
      // A strobe on the commit edge bypasses the shadow so it is never stale.
      disp_d    = bus.loadStrobe ? bus.loadValue : shadow_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end else if (bus.loadStrobe) begin
      shadow_d  = bus.loadValue;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    bus.anode = sel_to_anode(sel_q);
    if (reset || !bus.enable || in_blank || bus.blankMask[sel_q]) begin
      bus.anode = ANODE_OFF;
    end
  end

  assign bus.selection   = sel_q;
  assign bus.displayInfo = disp_q;
  assign bus.pending     = pending_q;
  assign bus.loadAck     = ack_q;

endmodule
